code_lock: RTL and testbench

CODE_LOCK -- requirements
Module: code_lock

---
 rtl/code_lock_pkg.sv | 20 ++
 rtl/code_lock_btn_decoder.sv | 32 +++
 rtl/code_lock.sv | 120 ++++++++++++
 tb/tb_code_lock.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared state encoding and widths for the keypad code lock.
package code_lock_pkg;
  localparam logic [2:0] ST_LOCKED   = 3'd0;
  localparam logic [2:0] ST_INPUT    = 3'd1;
  localparam logic [2:0] ST_VERIFY   = 3'd2;
  localparam logic [2:0] ST_ERROR    = 3'd3;
  localparam logic [2:0] ST_UNLOCKED = 3'd4;
  localparam logic [2:0] ST_LOCKOUT  = 3'd5;

  localparam int TRIES_W = 4;

  typedef enum logic [2:0] {
    S_LOCKED   = ST_LOCKED,
    S_INPUT    = ST_INPUT,
    S_VERIFY   = ST_VERIFY,
    S_ERROR    = ST_ERROR,
    S_UNLOCKED = ST_UNLOCKED,
    S_LOCKOUT  = ST_LOCKOUT
  } state_t;
endpackage

// File: rtl/code_lock_btn_decoder.sv
// Button press-edge detector: one event per press, one-hot check, index encoding.
module btn_decoder #(
  parameter int N_BTN = 4,
  parameter int DW    = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic             valid_press,
  output logic             invalid_press,
  output logic [DW-1:0]    digit
);
  logic [N_BTN-1:0] prev_btn;
  logic             press, onehot;

  always_ff @(posedge clk) begin
    if (reset) prev_btn <= '0;
    else       prev_btn <= btn;
  end

  // an event needs a fully released keypad on the previous cycle, so holds never repeat
  assign press         = (btn != '0) && (prev_btn == '0);
  assign onehot        = (btn & (btn - N_BTN'(1))) == '0;
  assign valid_press   = press && onehot;
  assign invalid_press = press && !onehot;

  always_comb begin
    digit = '0;
    for (int i = 0; i < N_BTN; i++)
      if (btn[i]) digit = DW'(i);
  end
endmodule

// File: rtl/code_lock.sv
// Keypad code lock: digit entry, one-cycle verify, retry budget and timed lockout.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*$clog2(N_BTN)-1:0] PASSWORD = 8'b00_01_10_11,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_BTN-1:0]              btn,
  input  logic                          enter,
  input  logic                          clear,
  output logic [2:0]                    state,
  output logic                          locked,
  output logic                          unlocked,
  output logic                          error,
  output logic                          lockout,
  output logic [$clog2(CODE_LEN+2)-1:0] digit_count,
  output logic [TRIES_W-1:0]            tries_left,
  output logic                          invalid
);
  localparam int DW = $clog2(N_BTN);
  localparam int CW = $clog2(CODE_LEN+2);
  localparam int SW = CODE_LEN*DW;
  localparam int TW = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES);

  state_t             st, st_n;
  logic [SW-1:0]      shift, shift_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               bad, bad_n;
  logic [TRIES_W-1:0] tries, tries_n;
  logic [TW-1:0]      timer, timer_n;
  logic               valid_press, invalid_press, match;
  logic [DW-1:0]      digit;

  btn_decoder #(.N_BTN(N_BTN), .DW(DW)) u_dec (
    .clk(clk), .reset(reset), .btn(btn),
    .valid_press(valid_press), .invalid_press(invalid_press), .digit(digit)
  );

  assign match = (cnt == CW'(CODE_LEN)) && (shift == PASSWORD) && !bad;

  always_comb begin
    st_n    = st;
    shift_n = shift;
    cnt_n   = cnt;
    bad_n   = bad;
    tries_n = tries;
    timer_n = timer;
    case (st)
      S_LOCKED: if (enter) begin
        st_n    = S_INPUT;
        shift_n = '0;
        cnt_n   = '0;
        bad_n   = 1'b0;
      end
      S_INPUT: begin
        if (clear)      st_n = S_LOCKED;
        else if (enter) st_n = S_VERIFY;
        else if (valid_press) begin
          shift_n = (shift << DW) | SW'(digit);
          // count sticks one past the code length so overflow can never match
          if (cnt != CW'(CODE_LEN+1)) cnt_n = cnt + CW'(1);
        end else if (invalid_press) bad_n = 1'b1;
      end
      S_VERIFY: begin
        if (match) begin
          st_n    = S_UNLOCKED;
          tries_n = TRIES_W'(MAX_TRIES);
        end else if (tries > TRIES_W'(1)) begin
          st_n    = S_ERROR;
          tries_n = tries - TRIES_W'(1);
        end else begin
          st_n    = S_LOCKOUT;
          tries_n = '0;
          timer_n = TW'(LOCKOUT_CYCLES-1);
        end
      end
      S_ERROR, S_UNLOCKED: if (clear) st_n = S_LOCKED;
      S_LOCKOUT: begin
        if (timer == '0) begin
          st_n    = S_LOCKED;
          tries_n = TRIES_W'(MAX_TRIES);
        end else timer_n = timer - TW'(1);
      end
      default: st_n = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_LOCKED;
      shift   <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      tries   <= TRIES_W'(MAX_TRIES);
      timer   <= '0;
      invalid <= 1'b0;
    end else begin
      st      <= st_n;
      shift   <= shift_n;
      cnt     <= cnt_n;
      bad     <= bad_n;
      tries   <= tries_n;
      timer   <= timer_n;
      invalid <= invalid_press;
    end
  end

  assign state       = st;
  assign locked      = (st == S_LOCKED);
  assign unlocked    = (st == S_UNLOCKED);
  assign error       = (st == S_ERROR);
  assign lockout     = (st == S_LOCKOUT);
  assign digit_count = cnt;
  assign tries_left  = tries;
endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_code_lock;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = '0;
  logic       enter = 1'b0, clear = 1'b0;
  logic [2:0] state;
  logic       locked, unlocked, error, lockout, invalid;
  logic [2:0] digit_count;
  logic [3:0] tries_left;

  logic       rst8 = 1'b1;
  logic [7:0] btn8 = '0;
  logic       enter8 = 1'b0, clear8 = 1'b0;
  logic [2:0] state8, dc8;
  logic       locked8, unlocked8, error8, lockout8, invalid8;
  logic [3:0] tries8;

  int total = 0, passed = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  code_lock dut (
    .clk(clk), .reset(reset), .btn(btn), .enter(enter), .clear(clear),
    .state(state), .locked(locked), .unlocked(unlocked), .error(error), .lockout(lockout),
    .digit_count(digit_count), .tries_left(tries_left), .invalid(invalid)
  );

  // digits 7,0,3,5,1,6
  code_lock #(.N_BTN(8), .CODE_LEN(6), .PASSWORD(18'b111_000_011_101_001_110)) dut8 (
    .clk(clk), .reset(rst8), .btn(btn8), .enter(enter8), .clear(clear8),
    .state(state8), .locked(locked8), .unlocked(unlocked8), .error(error8), .lockout(lockout8),
    .digit_count(dc8), .tries_left(tries8), .invalid(invalid8)
  );

  // Reference model: mode number, queue of entered digits, retry and lockout counters.
  int   pw[4] = '{0, 1, 2, 3};
  int   ms = 0, mtries = 3, mrem = 0, md;
  int   mq[$];
  bit   mbad = 0, minv = 0, mpress, moh, mok;
  logic [3:0] mprev = '0;

  always @(posedge clk) begin
    mpress = (btn != 0) && (mprev == 0);
    moh    = ($countones(btn) == 1);
    md = 0;
    for (int i = 0; i < 4; i++) if (btn[i]) md = i;
    if (reset) begin
      ms = 0; mq.delete(); mbad = 0; mtries = 3; mrem = 0; mprev = '0; minv = 0;
    end else begin
      minv = mpress && !moh;
      case (ms)
        0: if (enter) begin ms = 1; mq.delete(); mbad = 0; end
        1: if (clear) ms = 0;
           else if (enter) ms = 2;
           else if (mpress) begin
             if (!moh) mbad = 1;
             else if (mq.size() <= 4) mq.push_back(md);
           end
        2: begin
          mok = (mq.size() == 4) && !mbad;
          if (mok) for (int i = 0; i < 4; i++) if (mq[i] != pw[i]) mok = 0;
          if (mok) begin ms = 4; mtries = 3; end
          else if (mtries > 1) begin ms = 3; mtries--; end
          else begin ms = 5; mtries = 0; mrem = 16; end
        end
        3, 4: if (clear) ms = 0;
        5: begin mrem--; if (mrem == 0) begin ms = 0; mtries = 3; end end
        default: ms = 0;
      endcase
      mprev = btn;
    end
  end

  logic [15:0] exp_v, got_v;
  always @(negedge clk) if (armed) begin
    exp_v = {3'(ms), ms == 0, ms == 4, ms == 3, ms == 5,
             3'((mq.size() > 5) ? 5 : mq.size()), 4'(mtries), minv};
    got_v = {state, locked, unlocked, error, lockout, digit_count, tries_left, invalid};
    total++;
    if (exp_v === got_v) passed++;
    else $display("FAIL model t=%0t got %h expected %h (state/flags/count/tries/invalid)", $time, got_v, exp_v);
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic step(input logic [3:0] b, input logic e, input logic c);
    btn = b; enter = e; clear = c;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    step(b, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic step8(input logic [7:0] b, input logic e, input logic c);
    btn8 = b; enter8 = e; clear8 = c;
    @(negedge clk);
  endtask

  int n;
  logic [7:0] code8[6] = '{8'h80, 8'h01, 8'h08, 8'h20, 8'h02, 8'h40};

  initial begin
    @(negedge clk);
    step(0, 0, 0);
    reset = 1'b0;
    armed = 1;
    chk("reset_state", state, 0);
    chk("reset_locked", locked, 1);
    chk("reset_tries", tries_left, 3);
    chk("reset_count", digit_count, 0);

    // correct code
    step(0, 1, 0);
    chk("enter_input", state, 1);
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    chk("count_4", digit_count, 4);
    step(0, 1, 0);
    chk("verify_state", state, 2);
    step(0, 0, 0);
    chk("unlocked", unlocked, 1);
    chk("unlock_tries", tries_left, 3);
    step(0, 0, 1);
    chk("relock", state, 0);

    // three wrong attempts then lockout with clear held
    for (int a = 0; a < 3; a++) begin
      step(0, 1, 0);
      press(4'b0001); press(4'b0001); press(4'b0100); press(4'b1000);
      step(0, 1, 0);
      step(0, 0, 0);
      if (a < 2) begin
        chk("wrong_error", state, 3);
        chk("wrong_tries", tries_left, 2 - a);
        step(0, 0, 1);
      end
    end
    chk("lockout_entered", lockout, 1);
    chk("lockout_tries", tries_left, 0);
    n = 0;
    while (lockout && n < 40) begin n++; step(4'b0001, 1, 1); end
    step(0, 0, 0);
    chk("lockout_len", n, 16);
    chk("after_lockout", state, 0);
    chk("after_lockout_tries", tries_left, 3);

    // multi-button press poisons an otherwise correct entry
    step(0, 1, 0);
    step(4'b0011, 0, 0);
    chk("invalid_pulse", invalid, 1);
    step(0, 0, 0);
    chk("invalid_once", invalid, 0);
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("bad_error", state, 3);
    step(0, 0, 1);

    // held button counts once, overflow fails, clear beats enter
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(4'b0001, 0, 0);
    step(0, 0, 0);
    chk("hold_count", digit_count, 1);
    press(4'b0010); press(4'b0100); press(4'b1000); press(4'b0001);
    chk("overflow_count", digit_count, 5);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("overflow_error", state, 3);
    chk("overflow_tries", tries_left, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("clear_over_enter", state, 0);

    // reset during lockout and during entry
    step(0, 1, 0);
    press(4'b0010);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("lockout_again", lockout, 1);
    step(0, 0, 0); step(0, 0, 0);
    reset = 1'b1; step(0, 1, 1); reset = 1'b0;
    chk("rst_lockout_state", state, 0);
    chk("rst_lockout_tries", tries_left, 3);
    step(0, 1, 0);
    press(4'b0001); press(4'b0010);
    chk("mid_entry_count", digit_count, 2);
    reset = 1'b1; step(4'b0100, 0, 0); reset = 1'b0;
    chk("rst_input_state", state, 0);
    chk("rst_input_count", digit_count, 0);
    step(0, 0, 0);

    // wider configuration
    step8(0, 0, 0);
    rst8 = 1'b0;
    step8(0, 1, 0);
    for (int i = 0; i < 6; i++) begin step8(code8[i], 0, 0); step8(0, 0, 0); end
    chk("w8_count", dc8, 6);
    step8(0, 1, 0);
    chk("w8_verify", state8, 2);
    step8(0, 0, 0);
    chk("w8_unlocked", unlocked8, 1);
    chk("w8_tries", tries8, 3);

    // random traffic against the model; periodically feed the right code
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] b;
      r = $urandom_range(0, 99);
      if (r < 50)      b = '0;
      else if (r < 88) b = 4'(1 << $urandom_range(0, 3));
      else             b = 4'($urandom_range(0, 15));
      if (k % 400 == 200) begin
        step(0, 1, 0);
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        step(0, 1, 0);
      end
      reset = ($urandom_range(0, 299) == 0);
      step(b, $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end
    reset = 1'b0;
    step(0, 0, 0);

    armed = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
